// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle of the transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] d;
    logic             load;
    logic             ready;
    logic             q;
    logic             q_valid;
    logic             done;

    modport master (
        output d,
        output load,
        input  ready,
        input  q,
        input  q_valid,
        input  done
    );

    modport slave (
        input  d,
        input  load,
        output ready,
        output q,
        output q_valid,
        output done
    );

endinterface

// File: rtl/piso_tx_bit_counter.sv
// Bit position counter with clear/enable; flags the last bit of a word.
module bit_counter
    import piso_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == LAST);
    assign o_term = w_term;

    // Saturates at the last position so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_term) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a word on handshake and
// shifts it out one bit per clock, gapless when reloaded on the last bit.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_clr;
    logic             w_en;
    logic             w_term;
    logic             w_out_bit;
    logic             w_shift_st;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_term (w_term)
    );

    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};
    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = bus.d;
                    w_clr       = 1'b1;
                end
            end
            SHIFT: begin
                if (w_term) begin
                    // Last bit: a load here continues without a gap.
                    w_clr = 1'b1;
                    if (bus.load) begin
                        w_shreg_nxt = bus.d;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shreg_nxt = w_shifted;
                    end
                end else begin
                    w_shreg_nxt = w_shifted;
                    w_en        = 1'b1;
                end
            end
        endcase
    end

    assign w_shift_st  = (r_state == SHIFT);
    assign bus.q       = w_shift_st & w_out_bit;
    assign bus.q_valid = w_shift_st;
    assign bus.done    = w_shift_st & w_term;
    assign bus.ready   = !w_shift_st | w_term;

endmodule

// File: tb/tb_piso_tx.sv
// Directed table-driven bench for piso_tx (8-bit MSB-first and 4-bit LSB-first).
module tb_piso_tx;

    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] d;
        logic       ready;
        logic       q;
        logic       qv;
        logic       done;
    } vec_t;

    logic clk;
    logic rst;
    logic rst4;
    int   checks;
    int   failures;
    vec_t vecs[$];

    piso_tx_if #(.WIDTH(8)) bus8();
    piso_tx_if #(.WIDTH(4)) bus4();

    piso_tx #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    piso_tx #(
        .WIDTH     (4),
        .MSB_FIRST (1'b0)
    ) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string name, input int idx,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic [7:0] dd,
                       input logic rdy, input logic qq, input logic v,
                       input logic dn);
        vec_t e;
        e.rst = r; e.load = l; e.d = dd;
        e.ready = rdy; e.q = qq; e.qv = v; e.done = dn;
        vecs.push_back(e);
    endtask

    // Load d, then 7 idle cycles; bits is the hand-written q sequence.
    task automatic add_word(input logic [7:0] dd, input logic [7:0] bits);
        add(0, 1, dd, 0, bits[7], 1, 0);
        for (int i = 1; i < 8; i++)
            add(0, 0, 8'h55, (i == 7), bits[7-i], 1, (i == 7));
    endtask

    task automatic add_idle();
        add(0, 0, 8'h00, 1, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] exp4;
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        rst4 = 1'b1;
        bus8.load = 1'b0;
        bus8.d    = '0;
        bus4.load = 1'b0;
        bus4.d    = '0;

        // Reset with a simultaneous load: nothing starts
        add(1, 1, 8'hFF, 1, 0, 0, 0);
        add(1, 1, 8'hFF, 1, 0, 0, 0);
        add_idle();
        // Single word 1011_0010
        add_word(8'b1011_0010, 8'b1011_0010);
        add_idle();
        // Back-to-back A5 then 3C, second load in the done cycle
        add_word(8'hA5, 8'b1010_0101);
        add_word(8'h3C, 8'b0011_1100);
        add_idle();
        // Busy load of FF at cnt=3 of word 00 is ignored
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 0, 0, 1, 0);
        add(0, 1, 8'hFF, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 0, 0, 1, 0);
        add(0, 0, 8'hFF, 1, 0, 1, 1);
        add_idle();
        // Reset at cnt=4 of F0 aborts the word, then 81 is sent
        add(0, 1, 8'hF0, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0);
        add(1, 0, 8'h00, 1, 0, 0, 0);
        add_idle();
        add_word(8'h81, 8'b1000_0001);
        add_idle();

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            bus8.load = vecs[i].load;
            bus8.d    = vecs[i].d;
            @(posedge clk);
            @(negedge clk);
            chk("ready",   i, bus8.ready,   vecs[i].ready);
            chk("q",       i, bus8.q,       vecs[i].q);
            chk("q_valid", i, bus8.q_valid, vecs[i].qv);
            chk("done",    i, bus8.done,    vecs[i].done);
        end

        // WIDTH=4, LSB first: d=0001 -> q 1,0,0,0
        exp4 = 4'b0001;
        rst4 = 1'b0;
        bus4.load = 1'b1;
        bus4.d    = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        bus4.load = 1'b0;
        bus4.d    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            chk("w4_q",     100 + i, bus4.q,       exp4[i]);
            chk("w4_valid", 100 + i, bus4.q_valid, 1'b1);
            chk("w4_done",  100 + i, bus4.done,    (i == 3));
            chk("w4_ready", 100 + i, bus4.ready,   (i == 3));
            @(posedge clk);
            @(negedge clk);
        end
        chk("w4_idle_valid", 104, bus4.q_valid, 1'b0);
        chk("w4_idle_ready", 104, bus4.ready,   1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
